// File: rtl/kmp_prefix_table.sv
// KMP failure-table builder: copies the pattern out of a 1-cycle-latency ROM,
// then runs one longest-proper-prefix-suffix step per cycle and holds the
// finished table on a combinational random-read port.
module kmp_prefix_table #(
  parameter int unsigned PAT_LEN = 5,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] pat_addr_o,
  input  logic [DATA_W-1:0] pat_data_i,
  input  logic [ADDR_W-1:0] rd_idx_i,
  output logic [ADDR_W-1:0] rd_val_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              valid_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StCompute, StDone} state_e;

  state_e            state_q, state_d;
  // Load counter holds c-1 during LOAD cycle c; reaches PAT_LEN on the last one.
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   i_q, i_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pat_q [Depth];
  logic [DATA_W-1:0] pat_d [Depth];
  logic [ADDR_W-1:0] lps_q [Depth];
  logic [ADDR_W-1:0] lps_d [Depth];

  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] i_idx;

  assign wr_idx = cnt_q[ADDR_W-1:0] - ADDR_W'(1);
  assign i_idx  = i_q[ADDR_W-1:0];

  // Next-state logic: load sequencing and one table step per COMPUTE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    len_d   = len_q;
    valid_d = valid_q;
    pat_d   = pat_q;
    lps_d   = lps_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = StLoad;
          valid_d = 1'b0;
        end
      end
      StLoad: begin
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        // ROM data lags the address by one cycle, hence the c-2 slot.
        if (cnt_q != '0) begin
          pat_d[wr_idx] = pat_data_i;
        end
        if (cnt_q == (ADDR_W+1)'(PAT_LEN)) begin
          i_d      = (ADDR_W+1)'(1);
          len_d    = '0;
          lps_d[0] = '0;
          if (PAT_LEN == 1) begin
            state_d = StDone;
            valid_d = 1'b1;
          end else begin
            state_d = StCompute;
          end
        end
      end
      StCompute: begin
        if (pat_q[i_idx] == pat_q[len_q]) begin
          lps_d[i_idx] = len_q + ADDR_W'(1);
          len_d        = len_q + ADDR_W'(1);
          i_d          = i_q + (ADDR_W+1)'(1);
        end else if (len_q != '0) begin
          len_d = lps_q[len_q - ADDR_W'(1)];
        end else begin
          lps_d[i_idx] = '0;
          i_d          = i_q + (ADDR_W+1)'(1);
        end
        // Leave as soon as the final entry is written so no idle step is spent.
        if (i_d == (ADDR_W+1)'(PAT_LEN)) begin
          state_d = StDone;
          valid_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset clearing the pattern and table.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      i_q     <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < Depth; k++) begin
        pat_q[k] <= '0;
        lps_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      for (int k = 0; k < Depth; k++) begin
        pat_q[k] <= pat_d[k];
        lps_q[k] <= lps_d[k];
      end
    end
  end

  // Outputs: ROM address clamps at the last character, table read is combinational.
  always_comb begin
    pat_addr_o = '0;
    if (state_q == StLoad) begin
      if (cnt_q >= (ADDR_W+1)'(PAT_LEN - 1)) begin
        pat_addr_o = ADDR_W'(PAT_LEN - 1);
      end else begin
        pat_addr_o = cnt_q[ADDR_W-1:0];
      end
    end
    rd_val_o = '0;
    if ({1'b0, rd_idx_i} < (ADDR_W+1)'(PAT_LEN)) begin
      rd_val_o = lps_q[rd_idx_i];
    end
    busy_o  = (state_q == StLoad) || (state_q == StCompute);
    done_o  = (state_q == StDone);
    valid_o = valid_q;
  end

endmodule

// File: tb/tb_kmp_prefix_table.sv
// Directed bench for kmp_prefix_table with a behavioural 1-cycle ROM.
module tb_kmp_prefix_table;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] pat_addr;
  logic [7:0] pat_data;
  logic [2:0] rd_idx;
  logic [2:0] rd_val;
  logic       busy;
  logic       done;
  logic       valid;

  logic [7:0] rom [8];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string pat;
    string lps;
    int    done_cyc;
    bit    spam;
  } vec_t;

  vec_t vecs [4];

  kmp_prefix_table #(
    .PAT_LEN(5),
    .ADDR_W (3),
    .DATA_W (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .pat_addr_o(pat_addr),
    .pat_data_i(pat_data),
    .rd_idx_i  (rd_idx),
    .rd_val_o  (rd_val),
    .busy_o    (busy),
    .done_o    (done),
    .valid_o   (valid)
  );

  always #5 clk = ~clk;

  // Registered-read pattern ROM.
  always @(posedge clk) pat_data <= rom[pat_addr];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_rom(input string s);
    for (int k = 0; k < 8; k++) rom[k] = (k < 5) ? s[k] : 8'h00;
  endtask

  task automatic check_table(input string nm, input string lps);
    for (int k = 0; k < 8; k++) begin
      rd_idx = 3'(k);
      #1;
      chk($sformatf("%s rd[%0d]", nm, k), int'(rd_val), (k < 5) ? int'(lps[k]) - 48 : 0);
    end
  endtask

  // Start pulse counts as cycle 0; samples every following cycle on the falling edge.
  task automatic build(input vec_t v);
    int done_cyc   = -1;
    int ndone      = 0;
    int busy_first = -1;
    int busy_last  = -1;
    bit bad_valid  = 1'b0;
    bit bad_addr   = 1'b0;
    load_rom(v.pat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = v.spam && (c % 2 == 1) && (c < 10);
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
        if (!valid) bad_valid = 1'b1;
      end else if (done_cyc < 0 && valid) begin
        bad_valid = 1'b1;
      end
      if (c <= 6 && int'(pat_addr) != ((c - 1 < 4) ? c - 1 : 4)) bad_addr = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    chk({v.pat, " done cycle"}, done_cyc, v.done_cyc);
    chk({v.pat, " done count"}, ndone, 1);
    chk({v.pat, " busy first"}, busy_first, 1);
    chk({v.pat, " busy last"}, busy_last, v.done_cyc - 1);
    chk({v.pat, " valid window"}, int'(bad_valid), 0);
    chk({v.pat, " rom addr"}, int'(bad_addr), 0);
    chk({v.pat, " valid held"}, int'(valid), 1);
    check_table(v.pat, v.lps);
  endtask

  initial begin
    vecs[0] = '{pat: "ABCDE", lps: "00000", done_cyc: 11, spam: 1'b0};
    vecs[1] = '{pat: "AAAAA", lps: "01234", done_cyc: 11, spam: 1'b0};
    vecs[2] = '{pat: "ABABC", lps: "00120", done_cyc: 12, spam: 1'b0};
    vecs[3] = '{pat: "AABAA", lps: "01012", done_cyc: 12, spam: 1'b1};

    rst    = 1'b1;
    start  = 1'b0;
    rd_idx = '0;
    load_rom("ZZZZZ");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset valid", int'(valid), 0);
    chk("reset pat_addr", int'(pat_addr), 0);
    check_table("reset", "00000");

    // Each vector rebuilds on top of the previous valid table.
    for (int n = 0; n < 4; n++) build(vecs[n]);

    // Reset in the middle of COMPUTE, then rebuild from a new ROM image.
    load_rom("AABAA");
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 8) begin
        chk("mid busy", int'(busy), 1);
        rst = 1'b1;
      end
      @(posedge clk);
    end
    #1;
    chk("post-rst busy", int'(busy), 0);
    chk("post-rst valid", int'(valid), 0);
    chk("post-rst done", int'(done), 0);
    check_table("post-rst", "00000");
    @(negedge clk);
    rst = 1'b0;
    build(vecs[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
